// File: rtl/traffic_light_fsm.sv
// Intersection controller: programmable phase timer counted in 1 Hz ticks; lamps decoded from the state register (zero latency).
// No backpressure: every input is a level or a one-clk pulse sampled on each clk edge.
module traffic_light_fsm #(
   parameter int CNT_W      = 4,
   parameter int T_BASE_DEF = 6,
   parameter int T_EXT_DEF  = 3,
   parameter int T_YEL_DEF  = 2
) (
   input  logic             clk,
   input  logic             sys_reset,
   input  logic             tick_1hz,
   input  logic             reset_db,
   input  logic             walk_db,
   input  logic             reprogram_db,
   input  logic             sensor_in,
   input  logic [1:0]       time_sel,
   input  logic [CNT_W-1:0] time_val,
   output logic [2:0]       main_rgy,
   output logic [2:0]       side_rgy,
   output logic             walk_lamp,
   output logic             walk_pending,
   output logic [2:0]       state_out
);

   typedef enum logic [2:0] {
      MAIN_G  = 3'd0,
      MAIN_G2 = 3'd1,
      MAIN_Y  = 3'd2,
      WALK    = 3'd3,
      SIDE_G  = 3'd4,
      SIDE_G2 = 3'd5,
      SIDE_Y  = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] BASE_DEF = CNT_W'(T_BASE_DEF);
   localparam logic [CNT_W-1:0] EXT_DEF  = CNT_W'(T_EXT_DEF);
   localparam logic [CNT_W-1:0] YEL_DEF  = CNT_W'(T_YEL_DEF);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, dur_d, base_d;
   logic [CNT_W-1:0] t_base_q, t_ext_q, t_yel_q;
   logic             walk_pend_q, walk_prev_q, reprog_prev_q;
   logic             walk_rise, reprog_rise, expire, illegal, enter_walk;

   // A programmed zero becomes a one-tick phase so the counter never wraps.
   function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   assign walk_rise   = walk_db & ~walk_prev_q;
   assign reprog_rise = reprogram_db & ~reprog_prev_q;
   assign expire      = tick_1hz && (cnt_q <= CNT_W'(1));
   assign base_d      = (time_sel == 2'd0) ? time_val : t_base_q;
   assign enter_walk  = expire && !illegal && (state_d == WALK);

   always_comb begin
      state_d = MAIN_G;
      dur_d   = t_base_q;
      illegal = 1'b0;
      case (state_q)
         MAIN_G:  begin state_d = MAIN_G2; dur_d = sensor_in ? t_ext_q : t_base_q; end
         MAIN_G2: begin state_d = MAIN_Y;  dur_d = t_yel_q; end
         MAIN_Y:  begin
            state_d = walk_pend_q ? WALK : SIDE_G;
            dur_d   = walk_pend_q ? t_ext_q : t_base_q;
         end
         WALK:    begin state_d = SIDE_G;  dur_d = t_base_q; end
         SIDE_G:  begin
            state_d = sensor_in ? SIDE_G2 : SIDE_Y;
            dur_d   = sensor_in ? t_ext_q : t_yel_q;
         end
         SIDE_G2: begin state_d = SIDE_Y;  dur_d = t_yel_q; end
         SIDE_Y:  begin state_d = MAIN_G;  dur_d = t_base_q; end
         default: illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge sys_reset) begin
      if (!sys_reset) begin
         state_q       <= MAIN_G;
         cnt_q         <= BASE_DEF;
         t_base_q      <= BASE_DEF;
         t_ext_q       <= EXT_DEF;
         t_yel_q       <= YEL_DEF;
         walk_pend_q   <= 1'b0;
         walk_prev_q   <= 1'b0;
         reprog_prev_q <= 1'b0;
      end else begin
         // Edge registers track through soft reset so release creates no false edge.
         walk_prev_q   <= walk_db;
         reprog_prev_q <= reprogram_db;
         if (reset_db) begin
            state_q     <= MAIN_G;
            cnt_q       <= BASE_DEF;
            t_base_q    <= BASE_DEF;
            t_ext_q     <= EXT_DEF;
            t_yel_q     <= YEL_DEF;
            walk_pend_q <= 1'b0;
         end else if (reprog_rise) begin
            case (time_sel)
               2'd0:    t_base_q <= time_val;
               2'd1:    t_ext_q  <= time_val;
               2'd2:    t_yel_q  <= time_val;
               default: ;
            endcase
            state_q <= MAIN_G;
            cnt_q   <= clamp1(base_d);
            if (walk_rise) walk_pend_q <= 1'b1;
         end else begin
            if (illegal || expire) begin
               state_q <= state_d;
               cnt_q   <= clamp1(dur_d);
            end else if (tick_1hz) begin
               cnt_q <= cnt_q - CNT_W'(1);
            end
            if (enter_walk)     walk_pend_q <= 1'b0;
            else if (walk_rise) walk_pend_q <= 1'b1;
         end
      end
   end

   always_comb begin
      main_rgy  = 3'b100;
      side_rgy  = 3'b100;
      walk_lamp = 1'b0;
      case (state_q)
         MAIN_G, MAIN_G2: main_rgy = 3'b001;
         MAIN_Y:          main_rgy = 3'b010;
         WALK:            walk_lamp = 1'b1;
         SIDE_G, SIDE_G2: side_rgy = 3'b001;
         SIDE_Y:          side_rgy = 3'b010;
         default:         main_rgy = 3'b100;
      endcase
   end

   assign walk_pending = walk_pend_q;
   assign state_out    = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm: phase-length table plus hand-written walk/reprogram/reset sequences.
module tb_traffic_light_fsm;

   logic       clk = 1'b0;
   logic       sys_reset = 1'b1;
   logic       tick_1hz = 1'b0, reset_db = 1'b0, walk_db = 1'b0, reprogram_db = 1'b0, sensor_in = 1'b0;
   logic [1:0] time_sel = 2'd0;
   logic [3:0] time_val = 4'd0;
   logic [2:0] main_rgy, side_rgy, state_out;
   logic       walk_lamp, walk_pending;

   always #5 clk = ~clk;

   traffic_light_fsm dut (
      .clk(clk), .sys_reset(sys_reset), .tick_1hz(tick_1hz), .reset_db(reset_db),
      .walk_db(walk_db), .reprogram_db(reprogram_db), .sensor_in(sensor_in),
      .time_sel(time_sel), .time_val(time_val), .main_rgy(main_rgy), .side_rgy(side_rgy),
      .walk_lamp(walk_lamp), .walk_pending(walk_pending), .state_out(state_out)
   );

   localparam logic [2:0] MG = 3'd0, MG2 = 3'd1, MY = 3'd2, WK = 3'd3, SG = 3'd4, SG2 = 3'd5, SY = 3'd6;

   typedef struct {
      logic       sensor;
      logic [2:0] st;
      int         len;
   } vec_t;

   vec_t tv[11];
   int   n_cmp = 0, n_err = 0, tot = 0, exp_tot = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [6:0] lamps(input logic [2:0] s);
      case (s)
         MG, MG2: return 7'b001_100_0;
         MY:      return 7'b010_100_0;
         WK:      return 7'b100_100_1;
         SG, SG2: return 7'b100_001_0;
         SY:      return 7'b100_010_0;
         default: return 7'b000_000_0;
      endcase
   endfunction

   task automatic do_tick();
      @(negedge clk) tick_1hz = 1'b1;
      @(negedge clk) tick_1hz = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic measure(input logic [2:0] st, input int len);
      int n = 0;
      chk($sformatf("state_entry s%0d", st), state_out, st);
      chk($sformatf("lamps s%0d", st), {main_rgy, side_rgy, walk_lamp}, lamps(st));
      while (state_out == st && n < 40) begin
         do_tick();
         n++;
      end
      chk($sformatf("phase_len s%0d", st), n, len);
      tot += n;
   endtask

   task automatic run_table(input int lo, input int hi, input string nm);
      tot = 0;
      exp_tot = 0;
      for (int i = lo; i <= hi; i++) begin
         sensor_in = tv[i].sensor;
         measure(tv[i].st, tv[i].len);
         exp_tot += tv[i].len;
      end
      chk(nm, tot, exp_tot);
   endtask

   task automatic pulse_walk();
      @(negedge clk) walk_db = 1'b1;
      @(negedge clk) walk_db = 1'b0;
   endtask

   task automatic reprog(input logic [1:0] sel, input logic [3:0] val);
      @(negedge clk);
      time_sel = sel;
      time_val = val;
      reprogram_db = 1'b1;
      @(negedge clk) reprogram_db = 1'b0;
   endtask

   initial begin
      tv[0]  = '{1'b0, MG, 6};  tv[1]  = '{1'b0, MG2, 6}; tv[2]  = '{1'b0, MY, 2};
      tv[3]  = '{1'b0, SG, 6};  tv[4]  = '{1'b0, SY, 2};
      tv[5]  = '{1'b1, MG, 6};  tv[6]  = '{1'b1, MG2, 3}; tv[7]  = '{1'b1, MY, 2};
      tv[8]  = '{1'b1, SG, 6};  tv[9]  = '{1'b1, SG2, 3}; tv[10] = '{1'b1, SY, 2};

      // Asynchronous reset before any clock edge.
      #1 sys_reset = 1'b0;
      #1;
      chk("rst_state", state_out, MG);
      chk("rst_lamps", {main_rgy, side_rgy, walk_lamp}, 7'b001_100_0);
      chk("rst_walk_pending", walk_pending, 1'b0);
      repeat (2) @(negedge clk);
      sys_reset = 1'b1;

      run_table(0, 4, "period_default");
      run_table(5, 10, "period_sensor");
      sensor_in = 1'b0;

      // Walk request served after MAIN_Y, second press during WALK served next cycle.
      pulse_walk();
      chk("walk_latch", walk_pending, 1'b1);
      measure(MG, 6); measure(MG2, 6); measure(MY, 2);
      chk("walk_clear_on_entry", walk_pending, 1'b0);
      pulse_walk();
      chk("walk_relatch_in_walk", walk_pending, 1'b1);
      measure(WK, 3); measure(SG, 6); measure(SY, 2);
      measure(MG, 6); measure(MG2, 6); measure(MY, 2);
      chk("walk_clear_second", walk_pending, 1'b0);
      measure(WK, 3); measure(SG, 6); measure(SY, 2);

      // Rising walk edge coinciding with WALK entry: the clear wins.
      pulse_walk();
      measure(MG, 6); measure(MG2, 6);
      do_tick();
      chk("coinc_pre_state", state_out, MY);
      @(negedge clk);
      tick_1hz = 1'b1;
      walk_db = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0;
      chk("coinc_state", state_out, WK);
      chk("coinc_pending", walk_pending, 1'b0);
      walk_db = 1'b0;
      repeat (8) @(negedge clk);
      measure(WK, 3); measure(SG, 6); measure(SY, 2);

      // Reprogram base to 4 mid SIDE_G.
      measure(MG, 6); measure(MG2, 6); measure(MY, 2);
      do_tick(); do_tick();
      reprog(2'd0, 4'd4);
      chk("reprog_force_main", state_out, MG);
      measure(MG, 4); measure(MG2, 4); measure(MY, 2); measure(SG, 4); measure(SY, 2);
      reprog(2'd2, 4'd0);
      measure(MG, 4); measure(MG2, 4); measure(MY, 1); measure(SG, 4); measure(SY, 1);
      reprog(2'd3, 4'd9);
      measure(MG, 4); measure(MG2, 4); measure(MY, 1);

      // Soft reset held during SIDE_G with a pending walk and base reprogrammed to 9.
      reprog(2'd0, 4'd9);
      measure(MG, 9); measure(MG2, 9); measure(MY, 1);
      do_tick(); do_tick();
      pulse_walk();
      chk("pre_softrst_pending", walk_pending, 1'b1);
      @(negedge clk);
      reset_db = 1'b1;
      tick_1hz = 1'b1;
      repeat (5) @(negedge clk);
      chk("softrst_state", state_out, MG);
      chk("softrst_pending", walk_pending, 1'b0);
      reset_db = 1'b0;
      tick_1hz = 1'b0;
      repeat (9) @(negedge clk);
      measure(MG, 6); measure(MG2, 6); measure(MY, 2); measure(SG, 6);

      // Asynchronous sys_reset between edges, mid SIDE_Y.
      do_tick();
      @(posedge clk);
      #2 sys_reset = 1'b0;
      #1;
      chk("async_state", state_out, MG);
      chk("async_lamps", {main_rgy, side_rgy, walk_lamp}, 7'b001_100_0);
      @(negedge clk) sys_reset = 1'b1;
      run_table(0, 4, "period_after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
